// File: rtl/cic_decim_ctrl_if.sv
// Handshake and status bundle between the CIC integrator section, the
// sequencing controller and the comb chain.
interface cic_decim_ctrl_if #(
  parameter int R_BITS = 7
);
  logic              in_valid;
  logic              cfg_write;
  logic [R_BITS-1:0] cfg_rate;
  logic              cfg_busy;
  logic              cfg_err;
  logic [R_BITS-1:0] rate;
  logic [R_BITS-1:0] phase;
  logic              comb_valid;
  logic              comb_rst;
  logic              out_valid;

  modport master (
    output in_valid, cfg_write, cfg_rate,
    input  cfg_busy, cfg_err, rate, phase, comb_valid, comb_rst, out_valid
  );

  modport slave (
    input  in_valid, cfg_write, cfg_rate,
    output cfg_busy, cfg_err, rate, phase, comb_valid, comb_rst, out_valid
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimator comb-chain sequencer: divides the integrator sample rate by R,
// hides comb outputs until the delay lines are warm, and re-warms on rate change.
module cic_decim_ctrl #(
  parameter int MAX_R      = 64,
  parameter int R_DEFAULT  = 8,
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cic_decim_ctrl_if.slave       bus
);
  localparam int R_BITS  = $clog2(MAX_R + 1);
  localparam int W       = STAGES * DIFF_DELAY;
  localparam int WC_BITS = $clog2(W + 1);

  localparam logic [R_BITS-1:0]  RATE_MIN  = R_BITS'(2);
  localparam logic [R_BITS-1:0]  RATE_MAX  = R_BITS'(MAX_R);
  localparam logic [R_BITS-1:0]  RATE_RST  = R_BITS'(R_DEFAULT);
  localparam logic [R_BITS-1:0]  ONE_R     = R_BITS'(1);
  localparam logic [WC_BITS-1:0] WARM_LAST = WC_BITS'(W - 1);
  localparam logic [WC_BITS-1:0] ONE_W     = WC_BITS'(1);

  typedef enum logic [1:0] {WARMUP, RUN, DRAIN, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [R_BITS-1:0]   rate_reg, rate_next;
  logic [R_BITS-1:0]   phase_reg, phase_next;
  logic [R_BITS-1:0]   pending_reg, pending_next;
  logic [WC_BITS-1:0]  warm_cnt_reg, warm_cnt_next;
  logic                comb_valid_reg, comb_valid_next;
  logic                comb_rst_reg, comb_rst_next;
  logic                cfg_err_reg, cfg_err_next;
  logic                from_run_reg, from_run_next;
  logic [STAGES-1:0]   pipe_reg, pipe_next;

  logic out_strobe;
  logic rate_legal;
  logic accept;
  logic go_run;

  // One flop per comb stage: a strobe emerges exactly STAGES cycles after comb_valid.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = comb_valid_reg;
      end else begin : g_tail
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  assign out_strobe = pipe_reg[STAGES-1];
  assign rate_legal = (bus.cfg_rate >= RATE_MIN) && (bus.cfg_rate <= RATE_MAX);
  assign accept     = bus.cfg_write && rate_legal &&
                      ((state_reg == WARMUP) || (state_reg == RUN));

  always_comb begin
    state_next      = state_reg;
    rate_next       = rate_reg;
    phase_next      = phase_reg;
    pending_next    = pending_reg;
    warm_cnt_next   = warm_cnt_reg;
    from_run_next   = from_run_reg;
    comb_valid_next = 1'b0;
    cfg_err_next    = bus.cfg_write && !accept;
    go_run          = 1'b0;

    case (state_reg)
      WARMUP, RUN: begin
        if (bus.in_valid) begin
          if (phase_reg == rate_reg - ONE_R) begin
            phase_next      = '0;
            comb_valid_next = 1'b1;
          end else begin
            phase_next = phase_reg + ONE_R;
          end
        end
        if ((state_reg == WARMUP) && out_strobe) begin
          warm_cnt_next = warm_cnt_reg + ONE_W;
          if (warm_cnt_reg == WARM_LAST) begin
            go_run     = 1'b1;
            state_next = RUN;
          end
        end
        // Strobes still in flight are only worth showing if the chain was warm.
        if (accept) begin
          pending_next  = bus.cfg_rate;
          from_run_next = (state_reg == RUN) || go_run;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (!comb_valid_reg && (pipe_reg == '0)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        rate_next     = pending_reg;
        phase_next    = '0;
        warm_cnt_next = '0;
        state_next    = WARMUP;
      end
      default: begin
        state_next = WARMUP;
      end
    endcase

    comb_rst_next = (state_next == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WARMUP;
      rate_reg       <= RATE_RST;
      phase_reg      <= '0;
      pending_reg    <= RATE_RST;
      warm_cnt_reg   <= '0;
      comb_valid_reg <= 1'b0;
      comb_rst_reg   <= 1'b0;
      cfg_err_reg    <= 1'b0;
      from_run_reg   <= 1'b0;
      pipe_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      rate_reg       <= rate_next;
      phase_reg      <= phase_next;
      pending_reg    <= pending_next;
      warm_cnt_reg   <= warm_cnt_next;
      comb_valid_reg <= comb_valid_next;
      comb_rst_reg   <= comb_rst_next;
      cfg_err_reg    <= cfg_err_next;
      from_run_reg   <= from_run_next;
      pipe_reg       <= pipe_next;
    end
  end

  assign bus.rate       = rate_reg;
  assign bus.phase      = phase_reg;
  assign bus.comb_valid = comb_valid_reg;
  assign bus.comb_rst   = comb_rst_reg;
  assign bus.cfg_err    = cfg_err_reg;
  assign bus.cfg_busy   = (state_reg == DRAIN) || (state_reg == FLUSH);
  assign bus.out_valid  = out_strobe &&
                          ((state_reg == RUN) || ((state_reg == DRAIN) && from_run_reg));
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Scoreboard bench for cic_decim_ctrl: a sample-level rate model predicts the
// edge of every comb_valid / out_valid strobe; a negedge monitor retires them.
module tb_cic_decim_ctrl;
  localparam int R_BITS = 7;
  localparam int STAGES = 3;
  localparam int W      = 6;
  localparam int MAX_R  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cic_decim_ctrl_if #(.R_BITS(R_BITS)) bus();

  cic_decim_ctrl #(
    .MAX_R(MAX_R), .R_DEFAULT(8), .STAGES(STAGES), .DIFF_DELAY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int rst_seen = 0;
  int exp_cv[$];
  int exp_ov[$];

  // Reference model state
  int m_r, m_cnt, m_d, m_pend;
  bit m_active;
  bit err_pend, err_exp;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (bus.comb_rst) rst_seen++;
    while (exp_cv.size() > 0 && exp_cv[0] < edge_cnt) chk("cv_missed", edge_cnt, exp_cv.pop_front());
    while (exp_ov.size() > 0 && exp_ov[0] < edge_cnt) chk("ov_missed", edge_cnt, exp_ov.pop_front());
    if (bus.comb_valid) begin
      $display("txn comb_valid edge=%0d rate=%0d", edge_cnt, bus.rate);
      if (exp_cv.size() == 0) chk("cv_extra", bus.comb_valid, 0);
      else chk("cv_time", edge_cnt, exp_cv.pop_front());
    end
    if (bus.out_valid) begin
      $display("txn out_valid edge=%0d", edge_cnt);
      if (exp_ov.size() == 0) chk("ov_extra", bus.out_valid, 0);
      else chk("ov_time", edge_cnt, exp_ov.pop_front());
    end
  end

  task automatic model_reset();
    m_r = 8; m_cnt = 0; m_d = 0; m_pend = 8; m_active = 1;
    err_pend = 0; err_exp = 0;
    exp_cv.delete();
    exp_ov.delete();
  endtask

  task automatic err_check();
    if (err_pend) begin
      chk("cfg_err", bus.cfg_err, err_exp);
      if (err_exp) err_exp = 0;
      else err_pend = 0;
    end
  endtask

  // Called at a negedge: check, drive one cycle of stimulus, advance to next negedge.
  task automatic step(input bit iv, input bit wr, input int wrate);
    err_check();
    if (m_active) begin
      chk("phase", bus.phase, m_cnt);
      chk("rate", bus.rate, m_r);
      chk("busy", bus.cfg_busy, 0);
    end
    bus.in_valid  = iv;
    bus.cfg_write = wr;
    bus.cfg_rate  = R_BITS'(wrate);
    if (m_active && iv) begin
      if (m_cnt == m_r - 1) begin
        m_cnt = 0;
        exp_cv.push_back(edge_cnt + 1);
        if (m_d >= W) exp_ov.push_back(edge_cnt + 1 + STAGES);
        m_d++;
      end else begin
        m_cnt++;
      end
    end
    if (wr) begin
      err_pend = 1;
      if (m_active && wrate >= 2 && wrate <= MAX_R) begin
        err_exp  = 0;
        m_pend   = wrate;
        m_active = 0;
      end else begin
        err_exp = 1;
      end
      $display("txn cfg_write rate=%0d expect_err=%0d", wrate, err_exp);
    end
    @(negedge clk);
    bus.cfg_write = 1'b0;
  endtask

  // Hold in_valid high (it must be ignored) until the rate change completes.
  task automatic drain_wait(input int exp_busy);
    int n = 0;
    int r0 = rst_seen;
    while (bus.cfg_busy && n < 40) begin
      err_check();
      bus.in_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    chk("drain_bound", n >= 40, 0);
    chk("busy_len", n, exp_busy);
    chk("comb_rst_pulses", rst_seen - r0, 1);
    m_r = m_pend; m_cnt = 0; m_d = 0; m_active = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.cfg_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bus.in_valid = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_rate = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rate", bus.rate, 8);
    chk("rst_phase", bus.phase, 0);
    chk("rst_cv", bus.comb_valid, 0);
    chk("rst_crst", bus.comb_rst, 0);
    chk("rst_busy", bus.cfg_busy, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_ov", bus.out_valid, 0);
    rst = 1'b0;

    // 1: continuous samples at R=8
    repeat (8 * 9) step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    chk("t1_cv_left", exp_cv.size(), 0);
    chk("t1_ov_left", exp_ov.size(), 0);

    // 2: sparse samples, fresh warm-up
    do_reset();
    repeat (64) begin
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
    end

    // 3: rate change coincident with phase completion in RUN
    while (m_cnt != 7) step(1, 0, 0);
    step(1, 1, 4);
    drain_wait(6);
    repeat (4 * 9) step(1, 0, 0);
    repeat (6) step(0, 0, 0);

    // 4: illegal writes, then a write rejected during DRAIN
    step(0, 1, 1);  step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0);  step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 65); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 16);
    chk("t4_busy", bus.cfg_busy, 1);
    step(0, 1, 4);
    drain_wait(1);
    repeat (4) step(0, 0, 0);

    // 5: reset while draining discards the pending rate
    step(0, 1, 16);
    chk("t5_busy", bus.cfg_busy, 1);
    r0 = rst_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rate", bus.rate, 8);
    chk("t5_busy_clr", bus.cfg_busy, 0);
    chk("t5_crst", bus.comb_rst, 0);
    chk("t5_cv", bus.comb_valid, 0);
    chk("t5_ov", bus.out_valid, 0);
    chk("t5_phase", bus.phase, 0);
    model_reset();
    repeat (8 * 7) step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    chk("t5_no_crst", rst_seen - r0, 0);

    // 6: MAX_R boundary
    step(0, 1, 64);
    drain_wait(2);
    repeat (64 * 7) step(1, 0, 0);
    repeat (8) step(0, 0, 0);

    chk("end_cv_left", exp_cv.size(), 0);
    chk("end_ov_left", exp_ov.size(), 0);
    chk("end_crst_total", rst_seen, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencing controller for the CIC decimator comb chain. Counts integrator-rate samples, issues one valid strobe to the comb (differentiator) stages every R samples, and tracks strobes through the comb pipeline. Suppresses outputs until the comb delay buffers hold valid history. Handles run-time decimation-rate changes by draining, clearing and re-warming the chain. Sits between the integrator section and the comb chain in the decimator top level.

Parameters:
MAX_R, 64, largest legal decimation ratio; R_BITS = $clog2(MAX_R+1)
R_DEFAULT, 8, ratio loaded at reset; must satisfy 2 <= R_DEFAULT <= MAX_R
STAGES, 3, number of comb stages; each stage has exactly 1 cycle valid-to-ready latency
DIFF_DELAY, 2, comb differential delay M; warm-up length W = STAGES*DIFF_DELAY decimated samples

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  one-cycle strobe per integrator-rate sample
cfg_write  in  1  request to load cfg_rate
cfg_rate  in  R_BITS  requested decimation ratio
cfg_busy  out  1  high while a rate change is in progress (DRAIN, FLUSH)
cfg_err  out  1  one-cycle pulse: cfg_write rejected
rate  out  R_BITS  active decimation ratio
phase  out  R_BITS  current sample-count phase, 0..rate-1
comb_valid  out  1  strobe to first comb stage
comb_rst  out  1  one-cycle clear pulse to comb stages and integrators
out_valid  out  1  decimated output at end of comb chain is valid

Behaviour:
- Reset: state=WARMUP, rate=R_DEFAULT, phase=0, warm_cnt=0, pipe=0. All strobe/flag outputs 0: comb_valid, comb_rst, cfg_busy, cfg_err, out_valid.
- States: WARMUP, RUN, DRAIN, FLUSH.
- Phase counter (WARMUP, RUN only): increments on in_valid. When phase==rate-1 and in_valid: phase<=0 and comb_valid<=1 (registered, high the next cycle for exactly 1 cycle). Otherwise comb_valid<=0.
- Pipeline tracker: STAGES-bit shift register, pipe[0]<=comb_valid. out_strobe=pipe[STAGES-1] is exactly STAGES cycles after comb_valid.
- WARMUP: out_valid=0. Each out_strobe increments warm_cnt. An out_strobe with warm_cnt==W-1 moves state to RUN. The first RUN out_strobe is the (W+1)th after entry.
- RUN: out_valid = out_strobe, combinational from pipe.
- cfg_write is accepted in WARMUP or RUN if 2 <= cfg_rate <= MAX_R. The value is latched into pending, and state goes to DRAIN next cycle.
- cfg_write with an illegal cfg_rate, or in DRAIN/FLUSH: ignored, cfg_err=1 the next cycle for 1 cycle. State and rate are unchanged.
- Same cycle as an accepted cfg_write, phase completion still issues comb_valid.
- DRAIN: in_valid is ignored and phase holds. out_valid continues for in-flight strobes only if entered from RUN. Exit to FLUSH when comb_valid==0 and pipe==0.
- FLUSH: exactly 1 cycle. comb_rst=1 (registered output, high during the FLUSH cycle). Also: rate<=pending, phase<=0, warm_cnt<=0. Next state is WARMUP.
- cfg_busy=1 in DRAIN and FLUSH, registered with state.
- Arithmetic: phase and rate are unsigned R_BITS. The phase compare uses rate-1, which never underflows because rate>=2. warm_cnt width is $clog2(W+1).
- rst in any state, including mid-DRAIN/FLUSH: pending is discarded and every register returns to its reset value the next cycle. No comb_rst pulse is generated; the system rst clears the comb stages directly.
- in_valid held high continuously is legal; one sample is counted per cycle.

Test Plan:
1. Defaults (R=8, STAGES=3, M=2, W=6); rst then in_valid high continuously -> comb_valid pulses after every 8th in_valid; first 6 out_strobes suppressed; out_valid first asserts 3 cycles after the 7th comb_valid, then every 8 cycles.
2. Sparse in_valid (every 3rd cycle), R=8 -> comb_valid once per 24 cycles; phase steps 0..7 and wraps to 0; no out_valid before the 7th decimated strobe.
3. In RUN, cfg_write cfg_rate=4 in the same cycle as phase==7 with in_valid -> that comb_valid still issued and its out_valid seen; cfg_busy high through DRAIN; 1-cycle comb_rst; rate=4, phase=0; WARMUP for 6 strobes, then out_valid every 4 samples.
4. Illegal writes: cfg_rate=1, cfg_rate=0, cfg_rate=65, and a legal write during DRAIN -> each gives a 1-cycle cfg_err; rate and state unchanged.
5. rst asserted in DRAIN with pending=16 -> next cycle rate=8, state WARMUP, cfg_busy=0, comb_rst never pulsed, pipe cleared.
6. MAX_R boundary: cfg_rate=64 accepted -> comb_valid every 64 in_valid; phase reaches 63 and wraps without overflow.
